// File: rtl/mem_cell_pkg.sv
// Shared types and constants for the mem_cell FIFO/LIFO buffer.
package mem_cell_pkg;

   localparam int DATA_W = 32;

   typedef enum logic [2:0] {
      MODE_FIFO = 3'b000,
      MODE_LIFO = 3'b001
   } mode_e;

   typedef enum logic [1:0] {
      RW_IDLE = 2'b00,
      RW_WR   = 2'b01,
      RW_RD   = 2'b10,
      RW_RDWR = 2'b11
   } rw_e;

endpackage

// File: rtl/mem_cell_storage.sv
// WIDTH x DATA_W register array: one synchronous write port, one asynchronous read port.
module mem_cell_storage
   import mem_cell_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int AW    = $clog2(WIDTH)
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [AW-1:0]     i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [AW-1:0]     i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [WIDTH];

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mem_cell.sv
// 32-bit FIFO/LIFO buffer with chip-enable gating and full/empty status.
// Optional sticky err output for illegal ops when MEM_CELL_ERR_EN is defined.
module mem_cell
   import mem_cell_pkg::*;
#(
   parameter int         WIDTH   = 8,
   parameter logic [2:0] CHIP_ID = 3'b111
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] Din,
   input  logic [2:0]        mode_in,
   input  logic [2:0]        chip_en,
   input  logic [1:0]        rw,
   output logic [DATA_W-1:0] Dout,
   output logic              full,
   output logic              empty
`ifdef MEM_CELL_ERR_EN
   ,output logic             err
`endif
);

   localparam int AW = $clog2(WIDTH);
   localparam int CW = AW + 1;

   logic [CW-1:0]     r_count;
   logic [AW-1:0]     r_rd_ptr;
   logic [AW-1:0]     r_wr_ptr;
   mode_e             r_mode;
   logic [DATA_W-1:0] r_dout;

   logic              w_sel;
   mode_e             w_mode;
   rw_e               w_rw;
   logic              w_flush;
   logic              w_empty;
   logic              w_full;
   logic              w_do_rd;
   logic              w_do_wr;
   logic              w_lifo;
   logic [AW-1:0]     w_top;
   logic [AW-1:0]     w_top_m1;
   logic [AW-1:0]     w_raddr;
   logic [AW-1:0]     w_waddr;
   logic [DATA_W-1:0] w_rdata;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(WIDTH - 1)) ? '0 : p + AW'(1);
   endfunction

   // Reserved mode codes collapse to FIFO so they never trigger a spurious flush.
   assign w_mode   = (mode_in == 3'(MODE_LIFO)) ? MODE_LIFO : MODE_FIFO;
   assign w_lifo   = (r_mode == MODE_LIFO);
   assign w_rw     = rw_e'(rw);
   assign w_sel    = (chip_en == CHIP_ID);
   assign w_flush  = w_sel && (w_mode != r_mode);
   assign w_empty  = (r_count == '0);
   assign w_full   = (r_count == CW'(WIDTH));
   assign w_top    = r_count[AW-1:0];
   assign w_top_m1 = AW'(r_count - CW'(1));

   always_comb begin
      w_do_rd = 1'b0;
      w_do_wr = 1'b0;
      if (w_sel && !w_flush) begin
         unique case (w_rw)
            RW_WR:   w_do_wr = !w_full;
            RW_RD:   w_do_rd = !w_empty;
            RW_RDWR: begin
               w_do_rd = !w_empty;
               w_do_wr = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // LIFO read+write on a non-empty stack overwrites the current top in place.
   assign w_raddr = w_lifo ? w_top_m1 : r_rd_ptr;
   assign w_waddr = w_lifo ? (w_do_rd ? w_top_m1 : w_top) : r_wr_ptr;

   mem_cell_storage #(
      .WIDTH (WIDTH),
      .AW    (AW)
   ) u_storage (
      .clk     (clk),
      .i_we    (w_do_wr),
      .i_waddr (w_waddr),
      .i_wdata (Din),
      .i_raddr (w_raddr),
      .o_rdata (w_rdata)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count  <= '0;
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_mode   <= MODE_FIFO;
         r_dout   <= '0;
      end else if (w_flush) begin
         r_count  <= '0;
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_mode   <= w_mode;
      end else begin
         if (w_do_rd) r_dout <= w_rdata;
         if (w_do_wr && !w_do_rd)      r_count <= r_count + CW'(1);
         else if (w_do_rd && !w_do_wr) r_count <= r_count - CW'(1);
         if (!w_lifo) begin
            if (w_do_rd) r_rd_ptr <= ptr_inc(r_rd_ptr);
            if (w_do_wr) r_wr_ptr <= ptr_inc(r_wr_ptr);
         end
      end
   end

`ifdef MEM_CELL_ERR_EN
   logic r_err;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_err <= 1'b0;
      end else if (w_sel && !w_flush &&
                   ((w_rw == RW_WR && w_full) || (w_rw == RW_RD && w_empty))) begin
         r_err <= 1'b1;
      end
   end

   assign err = r_err;
`endif

   assign Dout  = r_dout;
   assign full  = w_full;
   assign empty = w_empty;

endmodule

// File: tb/tb_mem_cell.sv
// Directed self-checking bench for mem_cell (FIFO, LIFO, gating, flush, async reset).
module tb_mem_cell;

   logic        clk;
   logic        reset;
   logic [31:0] Din;
   logic [2:0]  mode_in;
   logic [2:0]  chip_en;
   logic [1:0]  rw;
   logic [31:0] Dout;
   logic        full;
   logic        empty;
`ifdef MEM_CELL_ERR_EN
   logic        err;
`endif

   int n_total = 0;
   int n_bad   = 0;

   mem_cell #(
      .WIDTH   (8),
      .CHIP_ID (3'b111)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .Din     (Din),
      .mode_in (mode_in),
      .chip_en (chip_en),
      .rw      (rw),
      .Dout    (Dout),
      .full    (full),
      .empty   (empty)
`ifdef MEM_CELL_ERR_EN
      ,.err    (err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Apply one command for one rising edge; outputs are settled on return.
   task automatic cmd(input logic [1:0] r, input logic [31:0] d);
      @(negedge clk);
      rw  = r;
      Din = d;
      @(posedge clk);
      #1;
      rw  = 2'b00;
   endtask

   initial begin
      reset   = 1'b0;
      Din     = '0;
      mode_in = 3'b000;
      chip_en = 3'b111;
      rw      = 2'b00;

      // 1: reset state and idle
      #2;
      check("rst_dout", Dout, 32'h0);
      check("rst_empty", {31'b0, empty}, 32'd1);
      check("rst_full", {31'b0, full}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      cmd(2'b00, 32'hFFFF_FFFF);
      check("idle_empty", {31'b0, empty}, 32'd1);
      check("idle_dout", Dout, 32'h0);

      // 2: FIFO basic
      cmd(2'b01, 32'h11);
      cmd(2'b01, 32'h22);
      cmd(2'b01, 32'h33);
      check("fifo3_empty", {31'b0, empty}, 32'd0);
      cmd(2'b10, '0); check("fifo_rd0", Dout, 32'h11);
      cmd(2'b10, '0); check("fifo_rd1", Dout, 32'h22);
      cmd(2'b10, '0); check("fifo_rd2", Dout, 32'h33);
      check("fifo_empty_after", {31'b0, empty}, 32'd1);

      // 3: FIFO fill, overflow, drain, wrapped refill
      for (int i = 0; i < 8; i++) cmd(2'b01, 32'h100 + i);
      check("fill_full", {31'b0, full}, 32'd1);
      cmd(2'b01, 32'hDEAD);
      check("ovf_full", {31'b0, full}, 32'd1);
      for (int i = 0; i < 8; i++) begin
         cmd(2'b10, '0);
         check($sformatf("drain%0d", i), Dout, 32'h100 + i);
      end
      check("drain_empty", {31'b0, empty}, 32'd1);
      cmd(2'b01, 32'h5A);
      cmd(2'b01, 32'h5B);
      cmd(2'b10, '0); check("wrap_rd0", Dout, 32'h5A);
      cmd(2'b10, '0); check("wrap_rd1", Dout, 32'h5B);

      // 4: LIFO (mode change on an idle cycle flushes an already-empty buffer)
      mode_in = 3'b001;
      cmd(2'b00, '0);
      cmd(2'b01, 32'hA);
      cmd(2'b01, 32'hB);
      cmd(2'b01, 32'hC);
      cmd(2'b10, '0); check("lifo_rd0", Dout, 32'hC);
      cmd(2'b10, '0); check("lifo_rd1", Dout, 32'hB);
      cmd(2'b10, '0); check("lifo_rd2", Dout, 32'hA);
      check("lifo_empty", {31'b0, empty}, 32'd1);
      cmd(2'b10, '0); check("lifo_udf_hold", Dout, 32'hA);
`ifdef MEM_CELL_ERR_EN
      check("lifo_err", {31'b0, err}, 32'd1);
`endif
      // LIFO read+write: returns top and replaces it
      cmd(2'b01, 32'h1);
      cmd(2'b01, 32'h2);
      cmd(2'b11, 32'h9); check("lifo_rdwr_out", Dout, 32'h2);
      cmd(2'b10, '0);    check("lifo_rdwr_top", Dout, 32'h9);
      cmd(2'b10, '0);    check("lifo_rdwr_bot", Dout, 32'h1);

      // 5: chip not selected, then FIFO read+write on full
      chip_en = 3'b000;
      cmd(2'b01, 32'h77);
      check("nosel_empty", {31'b0, empty}, 32'd1);
      chip_en = 3'b111;
      mode_in = 3'b000;
      cmd(2'b00, '0);
      for (int i = 0; i < 8; i++) cmd(2'b01, 32'h200 + i);
      check("full2", {31'b0, full}, 32'd1);
      cmd(2'b11, 32'h300);
      check("rdwr_full_dout", Dout, 32'h200);
      check("rdwr_full_cnt", {31'b0, full}, 32'd1);
      for (int i = 1; i < 5; i++) begin
         cmd(2'b10, '0);
         check($sformatf("post_rdwr%0d", i), Dout, 32'h200 + i);
      end

      // 6: async reset with 4 entries stored, then mode-switch flush
      check("pre_rst_empty", {31'b0, empty}, 32'd0);
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check("mid_rst_empty", {31'b0, empty}, 32'd1);
      check("mid_rst_dout", Dout, 32'h0);
`ifdef MEM_CELL_ERR_EN
      check("mid_rst_err", {31'b0, err}, 32'd0);
`endif
      @(negedge clk);
      reset = 1'b1;
      cmd(2'b01, 32'h41);
      cmd(2'b01, 32'h42);
      check("pre_flush_empty", {31'b0, empty}, 32'd0);
      mode_in = 3'b001;
      cmd(2'b01, 32'h43);
      check("flush_empty", {31'b0, empty}, 32'd1);
      cmd(2'b01, 32'h44);
      cmd(2'b10, '0);
      check("post_flush_rd", Dout, 32'h44);
      check("post_flush_empty", {31'b0, empty}, 32'd1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
